apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- Upstream stage for the APB add slave and any other APB completer on the bus.
- Converts a simple valid/ready command interface (address, write flag, write data) into compliant APB SETUP/ACCESS transfers.
- Waits for pready, captures read data and returns a single-entry response with valid/ready handshake.
- One transfer in flight at a time; all APB outputs registered.

Parameters:
ADDR_W, 32, APB address width (paddr_o, cmd_addr_i)
DATA_W, 32, APB data width (pwdata_o, prdata_i, cmd_wdata_i, rsp_rdata_o)
TIMEOUT_CYCLES, 16, max ACCESS-phase cycles without pready before error (used only with optional feature)

Ports:
pclk  input  1  APB clock
preset_n  input  1  reset, asynchronous, active-low
cmd_valid_i  input  1  command request valid
cmd_ready_o  output  1  bridge can accept command
cmd_write_i  input  1  1=write, 0=read
cmd_addr_i  input  ADDR_W  transfer address
cmd_wdata_i  input  DATA_W  write data
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumer ready
rsp_rdata_o  output  DATA_W  read data (0 for writes)
rsp_err_o  output  1  transfer timed out
psel_o  output  1  APB select
penable_o  output  1  APB enable
paddr_o  output  ADDR_W  APB address
pwrite_o  output  1  APB write
pwdata_o  output  DATA_W  APB write data
prdata_i  input  DATA_W  APB read data
pready_i  input  1  APB ready

Behaviour:
- Reset (async, preset_n=0): state IDLE; psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o = 0; paddr_o, pwdata_o, rsp_rdata_o = 0; cmd_ready_o = 1 once reset releases. Reset mid-transfer drops psel/penable immediately; the transfer is abandoned and no response is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o = 1 (only in IDLE).
  - On cmd_valid_i=1, latch addr, write and wdata into paddr_o/pwrite_o/pwdata_o; next state SETUP.
- SETUP (exactly 1 cycle): psel_o=1, penable_o=0; next state ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1.
  - paddr_o, pwrite_o and pwdata_o are held stable from SETUP through the last ACCESS cycle.
  - On a clock edge with pready_i=1: if pwrite_o=0, capture prdata_i into rsp_rdata_o; if pwrite_o=1, set rsp_rdata_o=0. Set rsp_err_o=0, drop psel_o/penable_o, set rsp_valid_o=1, go to RESP.
  - pready_i is ignored in every state except ACCESS.
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o held stable.
  - When rsp_ready_i=1, clear rsp_valid_o and go to IDLE.
  - Stall on rsp_ready_i=0 is unbounded.
- Latency: with a zero-wait completer, command accept edge to rsp_valid_o = 3 edges. With the registered-pready add slave (pready rises 1 cycle after psel&penable), ACCESS lasts 2 cycles, so latency = 4 edges.
- Back-to-back: minimum 1 IDLE cycle between a response handshake and the next command accept.
- psel_o is never asserted in IDLE or RESP. penable_o is never 1 without psel_o.
- Commands presented while cmd_ready_o=0 are not consumed; the requester must hold them.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter (width clog2(TIMEOUT_CYCLES+1)) clears on SETUP and increments each ACCESS cycle with pready_i=0.
  - When the count reaches TIMEOUT_CYCLES with pready_i still 0, the transfer ends: psel/penable drop, rsp_err_o=1, rsp_rdata_o=0, go to RESP.
  - pready_i=1 on the same edge as the limit wins: normal completion, err=0.
- Not defined: no counter; ACCESS waits indefinitely; rsp_err_o tied 0.

Test Plan:
- Write: cmd write addr 0xA000 data 0xDEADBEEF to the add slave -> one SETUP cycle, then 2 ACCESS cycles with paddr/pwdata stable; rsp_valid_o=1, rsp_err_o=0, rsp_rdata_o=0; slave register holds 0xDEADBEEF.
- Readback: read 0xA000 after the write -> rsp_rdata_o=0xDEADBEEF, 4 edges after accept. Read 0xB000 -> rsp_rdata_o=0.
- Response backpressure: hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and data stable, psel_o=0, cmd_ready_o=0 throughout; accept resumes 1 cycle after the handshake.
- Wait states: completer holding pready_i=0 for 3 ACCESS cycles -> penable_o stays 1 for 4 cycles; psel/paddr unchanged.
- Reset mid-ACCESS: assert preset_n=0 -> psel_o, penable_o, rsp_valid_o = 0 the same cycle; after release, cmd_ready_o=1 and no stale response.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4: pready_i tied 0 -> after 4 ACCESS cycles rsp_err_o=1, rsp_rdata_o=0, psel_o=0.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB requester: valid/ready command in, one SETUP/ACCESS transfer, one response out.
// Define APB_MASTER_TIMEOUT_EN to end ACCESS with an error after TIMEOUT_CYCLES wait states.
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic done_ok;
  logic done_to;

  // pready only matters while the completer sees psel & penable
  assign done_ok = (state_q == S_ACCESS) && pready_i;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tcnt_q, tcnt_d;

  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == S_SETUP) begin
      tcnt_d = '0;
    end else if ((state_q == S_ACCESS) && !pready_i) begin
      tcnt_d = tcnt_q + CW'(1);
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  // the wait that would bring the count to the limit ends the transfer
  assign done_to = (state_q == S_ACCESS) && !pready_i &&
                   (tcnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign done_to = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (cmd_valid_i) begin
          paddr_d  = cmd_addr_i;
          pwrite_d = cmd_write_i;
          pwdata_d = cmd_wdata_i;
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      (state_q == S_SETUP): begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      (state_q == S_ACCESS): begin
        if (done_ok) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata_i;
          rsp_err_d   = 1'b0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (done_to) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      (state_q == S_RESP): begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;

  a_cfg: assert property (@(posedge pclk) TIMEOUT_CYCLES >= 1);

  a_en_sel: assert property (
    @(posedge pclk) disable iff (!preset_n)
    penable_o |-> psel_o);

  a_stable: assert property (
    @(posedge pclk) disable iff (!preset_n)
    (psel_o && penable_o) |->
      ($stable(paddr_o) && $stable(pwdata_o) && $stable(pwrite_o)));

endmodule
